dac_spi_scheduler: RTL and testbench

- Shares one serial DAC interface among `NUM_LANES` DAC output lanes (HPF/threshold datapath outputs), replacing the per-channel fixed SPI slot.
- Each lane posts a 16-bit sample with a request/ack handshake.
- The block arbitrates requests round-robin, formats a 24-bit command frame, and shifts it out on `DAC_SYNC`/`DAC_SCLK`/`DAC_DIN`.
- It sits between the per-lane DAC datapaths and the board DAC pins.

---
 rtl/dac_spi_scheduler.sv | 230 +++++++++++++++++++++++
 tb/tb_dac_spi_scheduler.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dac_spi_scheduler.sv
// Purpose: shares one serial DAC among NUM_LANES lanes; round-robin grant, 24-bit {00011,addr,data} frame.
// Latency: request seen in IDLE -> lane_ack + DAC_SYNC low next cycle; SYNC low 1+48*SCLK_DIV cycles, then GAP_CYCLES.
// Backpressure: lanes hold lane_req until lane_ack; no grant while a frame/gap runs or while DAC_en is low.
// Option: `define DAC_LANE0_PRIORITY_EN gives lane 0 strict priority; the others stay round-robin.
module dac_spi_scheduler #(
    parameter int NUM_LANES  = 8,
    parameter int SCLK_DIV   = 2,
    parameter int GAP_CYCLES = 2
) (
    input  logic                    dataclk,
    input  logic                    reset,
    input  logic                    DAC_en,
    input  logic [NUM_LANES-1:0]    lane_req,
    input  logic [16*NUM_LANES-1:0] lane_data,
    output logic [NUM_LANES-1:0]    lane_ack,
    output logic                    DAC_SYNC,
    output logic                    DAC_SCLK,
    output logic                    DAC_DIN,
    output logic                    busy,
    output logic [2:0]              grant_lane,
    output logic [15:0]             frames_sent
);

    localparam int              HW        = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;
    localparam int              GW        = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [HW-1:0]   HALF_LAST = HW'(SCLK_DIV - 1);
    localparam logic [GW-1:0]   GAP_LAST  = GW'(GAP_CYCLES - 1);
    localparam logic [4:0]      BIT_LAST  = 5'd23;
    localparam logic [2:0]      PTR_RESET = 3'(NUM_LANES - 1);

    typedef enum logic [1:0] {S_IDLE, S_GRANT, S_SHIFT, S_GAP} state_t;

    state_t         r_state;
    state_t         w_next;

    logic [23:0]    r_frame;
    logic [4:0]     r_bit;
    logic [HW-1:0]  r_half;
    logic           r_phase;        // 0: SCLK high half, 1: SCLK low half
    logic [GW-1:0]  r_gap;
    logic [2:0]     r_grant_lane;
    logic [2:0]     r_rr_ptr;       // round-robin search starts after this lane
    logic [15:0]    r_frames_sent;

    logic [7:0]     w_req8;
    logic [15:0]    w_words [8];
    logic [2:0]     w_idx;
    logic [2:0]     w_winner;
    logic           w_any;
    logic           w_start;
    logic           w_half_end;
    logic           w_frame_end;
    logic           w_gap_end;

    // Widen the lane buses to the 8-lane address space; unused lanes never request.
    for (genvar g = 0; g < 8; g++) begin : g_lane
        if (g < NUM_LANES) begin : g_used
            assign w_req8[g]  = lane_req[g];
            assign w_words[g] = lane_data[16*g +: 16];
        end else begin : g_unused
            assign w_req8[g]  = 1'b0;
            assign w_words[g] = 16'h0000;
        end
    end

`ifdef DAC_LANE0_PRIORITY_EN
    // Lane 0 wins outright; otherwise the nearest requester after the pointer among lanes 1..N-1.
    always_comb begin
        w_any    = 1'b0;
        w_winner = 3'd0;
        w_idx    = 3'd0;
        for (int k = NUM_LANES; k >= 1; k--) begin
            w_idx = 3'((int'(r_rr_ptr) + k) % NUM_LANES);
            if (w_req8[w_idx] && (w_idx != 3'd0)) begin
                w_any    = 1'b1;
                w_winner = w_idx;
            end
        end
        if (w_req8[0]) begin
            w_any    = 1'b1;
            w_winner = 3'd0;
        end
    end
`else
    // Nearest requester after the pointer wins; scanning downward leaves the closest one last.
    always_comb begin
        w_any    = 1'b0;
        w_winner = 3'd0;
        w_idx    = 3'd0;
        for (int k = NUM_LANES; k >= 1; k--) begin
            w_idx = 3'((int'(r_rr_ptr) + k) % NUM_LANES);
            if (w_req8[w_idx]) begin
                w_any    = 1'b1;
                w_winner = w_idx;
            end
        end
    end
`endif

    assign w_start     = (r_state == S_IDLE) && DAC_en && w_any;
    assign w_half_end  = (r_half == HALF_LAST);
    assign w_frame_end = (r_state == S_SHIFT) && w_half_end && r_phase && (r_bit == BIT_LAST);
    assign w_gap_end   = (r_gap == GAP_LAST);

    // State register.
    always_ff @(posedge dataclk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next state and pin decode; pins follow the state register so reset idles them at once.
    always_comb begin
        w_next   = r_state;
        DAC_SYNC = 1'b1;
        DAC_SCLK = 1'b0;
        DAC_DIN  = 1'b0;
        lane_ack = '0;
        busy     = (r_state != S_IDLE);
        case (r_state)
            S_IDLE: begin
                if (w_start) begin
                    w_next = S_GRANT;
                end
            end
            S_GRANT: begin
                DAC_SYNC = 1'b0;
                DAC_DIN  = r_frame[23];
                lane_ack = NUM_LANES'(1) << r_grant_lane;
                w_next   = S_SHIFT;
            end
            S_SHIFT: begin
                DAC_SYNC = 1'b0;
                DAC_SCLK = ~r_phase;
                DAC_DIN  = r_frame[23];
                if (w_frame_end) begin
                    w_next = S_GAP;
                end
            end
            S_GAP: begin
                if (w_gap_end) begin
                    w_next = S_IDLE;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Grant bookkeeping: last granted lane and the round-robin pointer.
    always_ff @(posedge dataclk or negedge reset) begin
        if (!reset) begin
            r_grant_lane <= PTR_RESET;
            r_rr_ptr     <= PTR_RESET;
        end else if (w_start) begin
            r_grant_lane <= w_winner;
`ifdef DAC_LANE0_PRIORITY_EN
            if (w_winner != 3'd0) begin
                r_rr_ptr <= w_winner;
            end
`else
            r_rr_ptr <= w_winner;
`endif
        end
    end

    // Frame shift register plus bit, half-period and gap counters.
    // The next bit is shifted in as a low half ends, so DIN only moves as SCLK rises.
    always_ff @(posedge dataclk or negedge reset) begin
        if (!reset) begin
            r_frame <= 24'h000000;
            r_bit   <= 5'd0;
            r_half  <= '0;
            r_phase <= 1'b0;
            r_gap   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_frame <= {5'b00011, w_winner, w_words[w_winner]};
                    end
                end
                S_GRANT: begin
                    r_bit   <= 5'd0;
                    r_half  <= '0;
                    r_phase <= 1'b0;
                end
                S_SHIFT: begin
                    if (w_half_end) begin
                        r_half  <= '0;
                        r_phase <= ~r_phase;
                        if (r_phase) begin
                            if (r_bit == BIT_LAST) begin
                                r_frame <= 24'h000000;
                                r_gap   <= '0;
                            end else begin
                                r_bit   <= r_bit + 5'd1;
                                r_frame <= {r_frame[22:0], 1'b0};
                            end
                        end
                    end else begin
                        r_half <= r_half + 1'b1;
                    end
                end
                S_GAP: begin
                    r_gap <= r_gap + 1'b1;
                end
                default: begin
                    r_gap <= '0;
                end
            endcase
        end
    end

    // Completed-frame counter; bumps on the cycle DAC_SYNC returns high and wraps.
    always_ff @(posedge dataclk or negedge reset) begin
        if (!reset) begin
            r_frames_sent <= 16'h0000;
        end else if (w_frame_end) begin
            r_frames_sent <= r_frames_sent + 16'd1;
        end
    end

    assign grant_lane  = r_grant_lane;
    assign frames_sent = r_frames_sent;

endmodule

// File: tb/tb_dac_spi_scheduler.sv
// Directed bench for dac_spi_scheduler at default parameters.
// Watches each frame on the pins, rebuilds the serial word and checks timing against hand-computed values.
// Lane-0 priority checks compile in when DAC_LANE0_PRIORITY_EN is defined.
module tb_dac_spi_scheduler;

    localparam int NL = 8;

    logic              dataclk = 1'b0;
    logic              reset;
    logic              DAC_en;
    logic [NL-1:0]     lane_req;
    logic [16*NL-1:0]  lane_data;
    logic [NL-1:0]     lane_ack;
    logic              DAC_SYNC;
    logic              DAC_SCLK;
    logic              DAC_DIN;
    logic              busy;
    logic [2:0]        grant_lane;
    logic [15:0]       frames_sent;

    int cyc = 0;
    int n_tests = 0;
    int n_fail = 0;

    dac_spi_scheduler #(.NUM_LANES(NL), .SCLK_DIV(2), .GAP_CYCLES(2)) dut (
        .dataclk     (dataclk),
        .reset       (reset),
        .DAC_en      (DAC_en),
        .lane_req    (lane_req),
        .lane_data   (lane_data),
        .lane_ack    (lane_ack),
        .DAC_SYNC    (DAC_SYNC),
        .DAC_SCLK    (DAC_SCLK),
        .DAC_DIN     (DAC_DIN),
        .busy        (busy),
        .grant_lane  (grant_lane),
        .frames_sent (frames_sent)
    );

    always #5 dataclk = ~dataclk;

    always @(posedge dataclk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] lane_word(input int i);
        return 16'(32'h3C5A ^ (i * 32'h1111));
    endfunction

    task automatic set_lane(input int i, input logic [15:0] w);
        lane_data[16*i +: 16] = w;
        lane_req[i] = 1'b1;
    endtask

    task automatic do_reset();
        reset     = 1'b0;
        DAC_en    = 1'b1;
        lane_req  = '0;
        lane_data = '0;
        repeat (3) @(negedge dataclk);
        reset = 1'b1;
        @(negedge dataclk);
    endtask

    // Waits for DAC_SYNC to fall, then samples every negedge until it rises again.
    // Returns the 24 bits seen at SCLK rises, SYNC-low length, rise count, the low-cycle index
    // of the first rise, the cycle of the fall, lane_ack at the fall, and whether DIN moved off a rise.
    task automatic watch_frame(input int en_drop_at, input bit drop_acked,
                               output logic [23:0] word, output int low_cyc, output int rises,
                               output int first_rise, output int fall_cyc,
                               output logic [NL-1:0] ack_seen, output bit glitch);
        int   guard;
        logic prev_sclk;
        logic prev_din;
        word = '0; low_cyc = 0; rises = 0; first_rise = 0; fall_cyc = -1;
        ack_seen = '0; glitch = 1'b0; guard = 0;
        while (DAC_SYNC === 1'b1 && guard < 2000) begin
            @(negedge dataclk);
            guard++;
        end
        if (guard >= 2000) chk("sync_fall_timeout", 32'(guard), 32'd0);
        fall_cyc  = cyc;
        ack_seen  = lane_ack;
        prev_sclk = 1'b0;
        prev_din  = DAC_DIN;
        while (DAC_SYNC === 1'b0 && low_cyc < 1000) begin
            low_cyc++;
            if (DAC_SCLK === 1'b1 && prev_sclk === 1'b0) begin
                rises++;
                if (rises == 1) first_rise = low_cyc;
                word = {word[22:0], DAC_DIN};
            end else if (DAC_DIN !== prev_din) begin
                glitch = 1'b1;
            end
            if (drop_acked) lane_req = lane_req & ~lane_ack;
            if (low_cyc == en_drop_at) DAC_en = 1'b0;
            prev_sclk = DAC_SCLK;
            prev_din  = DAC_DIN;
            @(negedge dataclk);
        end
        if (low_cyc >= 1000) chk("sync_rise_timeout", 32'(low_cyc), 32'd97);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        logic [23:0]   word;
        logic [23:0]   exp_w;
        logic [NL-1:0] ack;
        int            low, rises, first_rise, fall, prev_fall, req_c, lost, pre_cnt;
        int            ack_cnt [NL];
        bit            glitch;

        // ---- reset values, checked while reset is held and after release ----
        reset = 1'b0; DAC_en = 1'b1; lane_req = '0; lane_data = '0;
        repeat (2) @(negedge dataclk);
        chk("rst_sync",   32'(DAC_SYNC),    32'd1);
        chk("rst_sclk",   32'(DAC_SCLK),    32'd0);
        chk("rst_din",    32'(DAC_DIN),     32'd0);
        chk("rst_ack",    32'(lane_ack),    32'd0);
        chk("rst_busy",   32'(busy),        32'd0);
        chk("rst_grant",  32'(grant_lane),  32'd7);
        chk("rst_frames", 32'(frames_sent), 32'd0);
        reset = 1'b1;
        @(negedge dataclk);
        chk("idle_sync", 32'(DAC_SYNC), 32'd1);

        // ---- single frame: lane 3, 0xA5C3 ----
        @(posedge dataclk); #1;
        req_c = cyc;
        set_lane(3, 16'hA5C3);
        watch_frame(-1, 1'b1, word, low, rises, first_rise, fall, ack, glitch);
        chk("l3_ack_latency", 32'(fall - req_c), 32'd1);
        chk("l3_ack",         32'(ack),          32'h08);
        chk("l3_word",        32'(word),         32'h1BA5C3);
        chk("l3_sync_low",    32'(low),          32'd97);
        chk("l3_rises",       32'(rises),        32'd24);
        chk("l3_first_rise",  32'(first_rise),   32'd2);
        chk("l3_din_stable",  32'(glitch),       32'd0);
        chk("l3_frames",      32'(frames_sent),  32'd1);
        chk("l3_din_end",     32'(DAC_DIN),      32'd0);
        chk("l3_grant",       32'(grant_lane),   32'd3);
        chk("l3_ack_gone",    32'(lane_ack),     32'd0);
        chk("l3_busy_gap1",   32'(busy),         32'd1);
        @(negedge dataclk);
        chk("l3_busy_gap2",   32'(busy),         32'd1);
        @(negedge dataclk);
        chk("l3_busy_idle",   32'(busy),         32'd0);

`ifndef DAC_LANE0_PRIORITY_EN
        // ---- all lanes requesting: grants 0..7,0 every 100 cycles ----
        do_reset();
        for (int i = 0; i < NL; i++) begin
            set_lane(i, lane_word(i));
            ack_cnt[i] = 0;
        end
        prev_fall = 0;
        for (int f = 0; f < 9; f++) begin
            watch_frame(-1, 1'b0, word, low, rises, first_rise, fall, ack, glitch);
            exp_w = {5'b00011, 3'(f % 8), lane_word(f % 8)};
            chk("rr_word",  32'(word),       32'(exp_w));
            chk("rr_grant", 32'(grant_lane), 32'(f % 8));
            if (f > 0) chk("rr_period", 32'(fall - prev_fall), 32'd100);
            if (f < 8) begin
                for (int i = 0; i < NL; i++) if (ack[i]) ack_cnt[i]++;
            end
            prev_fall = fall;
        end
        for (int i = 0; i < NL; i++) chk("rr_ack_once", 32'(ack_cnt[i]), 32'd1);
        lane_req = '0;
`else
        // ---- lane 0 priority: lanes 0 and 5 held, lane 0 always wins ----
        do_reset();
        set_lane(0, 16'h0A0A);
        set_lane(5, 16'h5A5A);
        for (int f = 0; f < 3; f++) begin
            watch_frame(-1, 1'b0, word, low, rises, first_rise, fall, ack, glitch);
            chk("pri_lane0", 32'(word[18:16]), 32'd0);
            chk("pri_ack0",  32'(ack),         32'h01);
        end
        lane_req[0] = 1'b0;
        watch_frame(-1, 1'b0, word, low, rises, first_rise, fall, ack, glitch);
        chk("pri_lane5", 32'(word), 32'h1D5A5A);
        lane_req = '0;
`endif

        // ---- reset during bit 10 aborts the frame; request served again from bit 23 ----
        do_reset();
        set_lane(2, 16'h1234);
        lost = 0;
        while (DAC_SYNC === 1'b1 && lost < 100) begin
            @(negedge dataclk);
            lost++;
        end
        repeat (42) @(negedge dataclk);
        chk("b10_sclk_high", 32'(DAC_SCLK), 32'd1);
        pre_cnt = 32'(frames_sent);
        reset = 1'b0;
        #1;
        chk("b10_rst_sync",   32'(DAC_SYNC),    32'd1);
        chk("b10_rst_sclk",   32'(DAC_SCLK),    32'd0);
        chk("b10_rst_din",    32'(DAC_DIN),     32'd0);
        chk("b10_rst_frames", 32'(frames_sent), 32'(pre_cnt));
        @(negedge dataclk);
        reset = 1'b1;
        watch_frame(-1, 1'b1, word, low, rises, first_rise, fall, ack, glitch);
        chk("b10_word",   32'(word),        32'h1A1234);
        chk("b10_low",    32'(low),         32'd97);
        chk("b10_frames", 32'(frames_sent), 32'd1);

        // ---- DAC_en drops mid-frame: frame completes, then no new frame ----
        do_reset();
        set_lane(5, 16'h5555);
        set_lane(6, 16'h6666);
        watch_frame(48, 1'b0, word, low, rises, first_rise, fall, ack, glitch);
        chk("en_word",   32'(word),        32'h1D5555);
        chk("en_low",    32'(low),         32'd97);
        chk("en_frames", 32'(frames_sent), 32'd1);
        lost = 0;
        repeat (300) begin
            @(negedge dataclk);
            if (DAC_SYNC !== 1'b1) lost++;
        end
        chk("en_no_frame", 32'(lost), 32'd0);
        chk("en_idle",     32'(busy), 32'd0);
        DAC_en = 1'b1;
        watch_frame(-1, 1'b0, word, low, rises, first_rise, fall, ack, glitch);
        chk("en_resume", 32'(word), 32'h1E6666);
        lane_req = '0;

        // ---- frames_sent wraps 65535 -> 0 ----
        do_reset();
        force dut.r_frames_sent = 16'hFFFF;
        @(negedge dataclk);
        release dut.r_frames_sent;
        @(negedge dataclk);
        chk("wrap_preload", 32'(frames_sent), 32'h0000FFFF);
        set_lane(1, 16'hBEEF);
        watch_frame(-1, 1'b1, word, low, rises, first_rise, fall, ack, glitch);
        chk("wrap_word",   32'(word),        32'h19BEEF);
        chk("wrap_frames", 32'(frames_sent), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
